// File: rtl/ps2_keyboard_if.sv
// ps2_keyboard_if: byte-wide read port between the PS/2 keyboard receiver and memctrl.
interface ps2_keyboard_if;
    logic       rd;
    logic       clr_flags;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       kb_overflow;
    logic       kb_error;

    // Receiver side: takes pop/clear strobes, presents the FIFO head and flags.
    modport slave (
        input  rd,
        input  clr_flags,
        output kb_data,
        output kb_ready,
        output kb_overflow,
        output kb_error
    );

    // memctrl side.
    modport master (
        output rd,
        output clr_flags,
        input  kb_data,
        input  kb_ready,
        input  kb_overflow,
        input  kb_error
    );
endinterface

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard receiver with a 2^FIFO_AW byte show-ahead FIFO.
// Pins are synchronised, glitch-filtered, and sampled on the filtered falling
// edge of ps2_clk. The frame is start(0), 8 data bits LSB first, parity, stop(1).
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames whose 9 bits
// (data + parity) are not odd. Without it, the parity bit is sampled but ignored.
module ps2_keyboard #(
    parameter int unsigned FIFO_AW    = 4,
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 25000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ps2_clk,
    input  logic          ps2_dat,
    ps2_keyboard_if.slave bus
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;
    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PARITY_CHECK = 1'b1;
`else
    localparam bit PARITY_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Synchronisers and filters; index 1 = ps2_clk, index 0 = ps2_dat.
    logic [1:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic [1:0]       sync_s;
    logic [1:0]       filt;
    logic [FLT_W-1:0] flt_cnt [2];
    logic             clk_prev;
    logic             fall_c;
    logic             dat_c;

    // Receive FSM state.
    state_t          state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic [TO_W-1:0] to_cnt;
    logic            push_req;
    logic [7:0]      push_data;
    logic            parity_ok_c;
    logic            push_c;
    logic            timeout_c;
    logic            err_set_c;

    // FIFO state.
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] rd_ptr_n;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_n;
    logic               pop_c;
    logic               push_ok_c;
    logic [7:0]         head_c;

    // Two-flop synchronisers; bus idles high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
        end
    end

    assign sync_s = {clk_sync[1], dat_sync[1]};

    // Glitch filter: a line follows its input only after FILTER_LEN equal differing samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt       <= 2'b11;
            flt_cnt[0] <= '0;
            flt_cnt[1] <= '0;
            clk_prev   <= 1'b1;
        end else begin
            clk_prev <= filt[1];
            for (int i = 0; i < 2; i++) begin
                if (sync_s[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FLT_W'(FILTER_LEN - 1)) begin
                    filt[i]    <= sync_s[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + FLT_W'(1);
                end
            end
        end
    end

    assign fall_c = clk_prev & ~filt[1];
    assign dat_c  = filt[0];

    // Frame decode: good frame requests a push, bad stop/parity or stall raises the error.
    assign parity_ok_c = PARITY_CHECK ? (^{shreg, par_bit}) : 1'b1;
    assign push_c      = fall_c && (state == S_STOP) && dat_c && parity_ok_c;
    assign timeout_c   = (state != S_IDLE) && !fall_c && (to_cnt == TO_W'(TIMEOUT - 1));
    assign err_set_c   = (fall_c && (state == S_STOP) && !(dat_c && parity_ok_c)) || timeout_c;

    // Receive FSM, advanced only by filtered falling edges of ps2_clk.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            push_req  <= 1'b0;
            push_data <= 8'h00;
        end else begin
            push_req <= push_c;
            if (push_c) begin
                push_data <= shreg;
            end
            if (state == S_IDLE) begin
                to_cnt <= '0;
                if (fall_c && !dat_c) begin
                    state   <= S_DATA;
                    bit_cnt <= 3'd0;
                end
            end else if (timeout_c) begin
                state  <= S_IDLE;
                to_cnt <= '0;
            end else if (!fall_c) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
                case (state)
                    S_DATA: begin
                        shreg   <= {dat_c, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_bit <= dat_c;
                        state   <= S_STOP;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // FIFO next-state: push accepted when not full or when a pop frees a slot.
    assign pop_c     = bus.rd && (count != '0);
    assign push_ok_c = push_req && ((count < CNT_W'(DEPTH)) || pop_c);

    always_comb begin
        count_n  = count;
        rd_ptr_n = rd_ptr;
        if (push_ok_c && !pop_c) begin
            count_n = count + CNT_W'(1);
        end else if (!push_ok_c && pop_c) begin
            count_n = count - CNT_W'(1);
        end
        if (pop_c) begin
            rd_ptr_n = rd_ptr + FIFO_AW'(1);
        end
        // Forward the byte being written when it becomes the new head.
        if (push_ok_c && (wr_ptr == rd_ptr_n)) begin
            head_c = push_data;
        end else begin
            head_c = mem[rd_ptr_n];
        end
    end

    // FIFO storage.
    always_ff @(posedge clock) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers, registered read port and sticky flags (set beats clear).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            bus.kb_data     <= 8'h00;
            bus.kb_ready    <= 1'b0;
            bus.kb_overflow <= 1'b0;
            bus.kb_error    <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            rd_ptr       <= rd_ptr_n;
            count        <= count_n;
            bus.kb_ready <= (count_n != '0);
            bus.kb_data  <= (count_n != '0) ? head_c : 8'h00;
            if (push_req && !push_ok_c) begin
                bus.kb_overflow <= 1'b1;
            end else if (bus.clr_flags) begin
                bus.kb_overflow <= 1'b0;
            end
            if (err_set_c) begin
                bus.kb_error <= 1'b1;
            end else if (bus.clr_flags) begin
                bus.kb_error <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: scoreboard bench for ps2_keyboard. The PS/2 clock is run
// much faster than a real keyboard and TIMEOUT is scaled down to keep runs short.
module tb_ps2_keyboard;
    localparam int unsigned TO   = 300;
    localparam int unsigned HALF = 12;
    localparam int unsigned FLEN = 4;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic clock   = 1'b0;
    logic reset   = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;

    ps2_keyboard_if bus();

    ps2_keyboard #(
        .FIFO_AW    (4),
        .FILTER_LEN (FLEN),
        .TIMEOUT    (TO)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int         chk_cnt  = 0;
    int         pass_cnt = 0;
    logic [7:0] exp_q[$];
    bit         err_exp    = 1'b0;
    bit         auto_drain = 1'b0;
    int         pop_req    = 0;
    int         pop_done   = 0;
    int         lat_cycles = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One PS/2 bit: data set while clock high, then a low and a high phase.
    task automatic ps2_bit(input logic b, input bit lat);
        @(negedge clock);
        ps2_dat = b;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        for (int k = 1; k <= int'(HALF); k++) begin
            @(posedge clock);
            #1;
            if (lat && lat_cycles < 0 && bus.kb_ready) lat_cycles = k;
        end
        @(negedge clock);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clock);
    endtask

    // Full frame; the reference model decides the outcome before the stop edge.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input bit lat);
        logic par;
        par = ~(^d) ^ bad_par;
        lat_cycles = -1;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
        ps2_bit(par, 1'b0);
        if (!bad_stop && !(PCHK && bad_par)) begin
            if (exp_q.size() < 16) exp_q.push_back(d);
        end else begin
            err_exp = 1'b1;
        end
        ps2_bit(~bad_stop, lat);
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(d[i], 1'b0);
    endtask

    task automatic clr_pulse();
        @(negedge clock);
        bus.clr_flags = 1'b1;
        @(negedge clock);
        bus.clr_flags = 1'b0;
        @(negedge clock);
    endtask

    task automatic pop_one();
        @(posedge clock);
        pop_req++;
        for (int k = 0; k < 50 && pop_done != pop_req; k++) @(posedge clock);
        @(negedge clock);
        check("pop_served", pop_done, pop_req);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clock);
        repeat (3) @(negedge clock);
        check("drain_done", exp_q.size(), 0);
    endtask

    // Monitor: compares every byte the DUT presents when it is popped.
    initial begin
        bus.rd = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset && bus.kb_ready && (auto_drain || pop_done < pop_req)) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_byte: got %02h expected none", bus.kb_data);
                end else begin
                    check("pop_data", bus.kb_data, exp_q.pop_front());
                end
                bus.rd = 1'b1;
                if (!auto_drain) pop_done++;
            end else begin
                bus.rd = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.clr_flags = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", {bus.kb_data, bus.kb_ready, bus.kb_overflow, bus.kb_error}, 0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Single 0x1C frame with latency measurement from the stop-bit edge.
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
        check("ready_latency", lat_cycles, 2 + FLEN + 2);
        check("t1_ready", bus.kb_ready, 1);
        check("t1_data", bus.kb_data, 8'h1C);
        check("t1_error", bus.kb_error, 0);
        pop_one();
        check("t1_empty", {bus.kb_ready, bus.kb_data}, 0);

        // Two bytes, popped one at a time.
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("t2_head0", bus.kb_data, 8'hF0);
        pop_one();
        check("t2_head1", bus.kb_data, 8'h1C);
        check("t2_ready1", bus.kb_ready, 1);
        pop_one();
        check("t2_empty", {bus.kb_ready, bus.kb_data}, 0);

        // Overflow: 17 frames into a 16-deep FIFO.
        for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        check("t3_overflow", bus.kb_overflow, 1);
        check("t3_head", bus.kb_data, 8'h01);
        auto_drain = 1'b1;
        wait_drain();
        check("t3_drained", bus.kb_ready, 0);
        check("t3_ovf_sticky", bus.kb_overflow, 1);
        clr_pulse();
        check("t3_ovf_clr", bus.kb_overflow, 0);

        // Parity bit flipped.
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        wait_drain();
        check("t4_parity_err", bus.kb_error, PCHK);
        clr_pulse();
        err_exp = 1'b0;
        check("t4_err_clr", bus.kb_error, 0);

        // Stall mid-frame past the timeout, then a clean 0x29.
        send_partial(8'h35, 4);
        ps2_dat = 1'b1;
        repeat (TO + 100) @(negedge clock);
        check("t5_timeout_err", bus.kb_error, 1);
        check("t5_no_byte", bus.kb_ready, 0);
        clr_pulse();
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        wait_drain();
        check("t5_after_err", bus.kb_error, 0);

        // Reset mid-frame with bytes queued and the error flag set.
        auto_drain = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        send_frame(8'h44, 1'b0, 1'b0, 1'b0);
        check("t6_queued", bus.kb_ready, 1);
        check("t6_err_set", bus.kb_error, 1);
        send_partial(8'h55, 3);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("t6_reset_now", {bus.kb_data, bus.kb_ready, bus.kb_overflow, bus.kb_error}, 0);
        exp_q.delete();
        err_exp = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("t6_after_reset", {bus.kb_data, bus.kb_ready, bus.kb_overflow, bus.kb_error}, 0);

        // Two-cycle clock glitch with data low must not start a frame.
        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        repeat (2) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clock);
        ps2_dat = 1'b1;
        repeat (20) @(negedge clock);
        auto_drain = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        wait_drain();
        check("t7_glitch_err", bus.kb_error, 0);

        // Random frames with occasional bad parity or stop bits.
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            bit bp;
            bit bs;
            d  = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 40)) @(negedge clock);
            send_frame(d, bp, bs, 1'b0);
            check("rand_err", bus.kb_error, err_exp);
            if (err_exp) begin
                clr_pulse();
                err_exp = 1'b0;
                check("rand_err_clr", bus.kb_error, 0);
            end
        end
        wait_drain();
        check("final_empty", {bus.kb_ready, bus.kb_data}, 0);
        check("final_ovf", bus.kb_overflow, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
